// File: rtl/fmap_pingpong_ram_if.sv
// Producer/consumer port bundle for the ping-pong feature-map buffer.
// master = layer side, slave = buffer side.
interface fmap_pingpong_ram_if #(
   parameter int CH = 6,
   parameter int DW = 16,
   parameter int AW = 8
);
   logic             wr_en;
   logic [AW-1:0]    waddr;
   logic [CH*DW-1:0] wdata;
   logic             wr_last;
   logic             wr_ready;
   logic             wr_bank;
   logic             wr_err;
   logic             rd_en;
   logic [AW-1:0]    raddr;
   logic             rd_done;
   logic             rd_avail;
   logic             rd_bank;
   logic [CH*DW-1:0] rdata;
   logic             rd_valid;

   modport master (
      output wr_en, waddr, wdata, wr_last,
      output rd_en, raddr, rd_done,
      input  wr_ready, wr_bank, wr_err,
      input  rd_avail, rd_bank, rdata, rd_valid
   );

   modport slave (
      input  wr_en, waddr, wdata, wr_last,
      input  rd_en, raddr, rd_done,
      output wr_ready, wr_bank, wr_err,
      output rd_avail, rd_bank, rdata, rd_valid
   );
endinterface

// File: rtl/fmap_pingpong_ram.sv
// Two-bank multi-channel feature-map buffer; producer fills one bank
// while the consumer reads the other, with FREE/FULL bank ownership.
module fmap_pingpong_ram #(
   parameter int CH    = 6,
   parameter int DW    = 16,
   parameter int DEPTH = 196,
   parameter int AW    = 8
) (
   input logic              clk,
   input logic              rst,
   fmap_pingpong_ram_if.slave bus
);

   typedef enum logic {
      FREE = 1'b0,
      FULL = 1'b1
   } bank_st_e;

   localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

   logic [CH*DW-1:0] mem [0:1][0:DEPTH-1];

   bank_st_e st_q [2];
   bank_st_e st_d [2];
   logic     wsel_q, wsel_d;
   logic     rsel_q, rsel_d;
   logic     err_q, err_d;
   logic     wr_fire, last_fire, rel, rd_fire;
   logic     w_in, r_in;

   assign bus.wr_ready = (st_q[wsel_q] == FREE);
   assign bus.rd_avail = (st_q[rsel_q] == FULL);
   assign bus.wr_bank  = wsel_q;
   assign bus.rd_bank  = rsel_q;
   assign bus.wr_err   = err_q;

   assign w_in      = ({1'b0, bus.waddr} < DEP);
   assign r_in      = ({1'b0, bus.raddr} < DEP);
   assign wr_fire   = bus.wr_en & bus.wr_ready;
   assign last_fire = wr_fire & bus.wr_last;
   assign rel       = bus.rd_done & bus.rd_avail;
   assign rd_fire   = bus.rd_en & bus.rd_avail;

   // bank ownership: write bank fills, read bank drains (never the same bank)
   always_comb begin
      st_d[0] = st_q[0];
      st_d[1] = st_q[1];
      wsel_d  = wsel_q;
      rsel_d  = rsel_q;
      err_d   = err_q;
      if (bus.wr_en && !bus.wr_ready)
         err_d = 1'b1;
      if (last_fire) begin
         st_d[wsel_q] = FULL;
         wsel_d       = ~wsel_q;
      end
      if (rel) begin
         st_d[rsel_q] = FREE;
         rsel_d       = ~rsel_q;
      end
   end

   // state, pointer and sticky error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q[0] <= FREE;
         st_q[1] <= FREE;
         wsel_q  <= 1'b0;
         rsel_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
         wsel_q  <= wsel_d;
         rsel_q  <= rsel_d;
         err_q   <= err_d;
      end
   end

   // storage write; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && wr_fire && w_in)
         mem[wsel_q][bus.waddr] <= bus.wdata;
   end

   // registered read port; out-of-range addresses return zero
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rdata    <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= rd_fire;
         if (rd_fire)
            bus.rdata <= r_in ? mem[rsel_q][bus.raddr] : '0;
      end
   end

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// Directed self-checking bench for fmap_pingpong_ram.
// Channel c of a word at address a holds {base+c, a}.
module tb_fmap_pingpong_ram;
   localparam int CH    = 6;
   localparam int DW    = 16;
   localparam int DEPTH = 196;
   localparam int AW    = 8;
   localparam int W     = CH*DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   fmap_pingpong_ram_if #(.CH(CH), .DW(DW), .AW(AW)) bus ();

   fmap_pingpong_ram #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] pat(input logic [7:0] base, input int a);
      logic [W-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++)
         r[c*DW +: DW] = {base + 8'(c), 8'(a)};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en   = 1'b0;
      bus.wr_last = 1'b0;
      bus.rd_en   = 1'b0;
      bus.rd_done = 1'b0;
   endtask

   task automatic fill(input logic [7:0] base, input int n, input bit last);
      for (int a = 0; a < n; a++) begin
         bus.wr_en   = 1'b1;
         bus.waddr   = AW'(a);
         bus.wdata   = pat(base, a);
         bus.wr_last = last && (a == n-1);
         step();
      end
      idle();
   endtask

   task automatic rd1(input int a, input logic [W-1:0] exp, input string tag);
      bus.rd_en = 1'b1;
      bus.raddr = AW'(a);
      step();
      bus.rd_en = 1'b0;
      chk({tag, "_v"}, bus.rd_valid, 1'b1);
      chk({tag, "_d"}, bus.rdata, exp);
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_wrdy"}, bus.wr_ready, 1'b1);
      chk({tag, "_ravl"}, bus.rd_avail, 1'b0);
      chk({tag, "_wbk"}, bus.wr_bank, 1'b0);
      chk({tag, "_rbk"}, bus.rd_bank, 1'b0);
      chk({tag, "_err"}, bus.wr_err, 1'b0);
      chk({tag, "_rv"}, bus.rd_valid, 1'b0);
      chk({tag, "_rd"}, bus.rdata, '0);
   endtask

   initial begin
      idle();
      bus.waddr = '0;
      bus.wdata = '0;
      bus.raddr = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      reset_chk("rst");

      fill(8'h00, DEPTH, 1'b1);
      chk("f0_wbk", bus.wr_bank, 1'b1);
      chk("f0_ravl", bus.rd_avail, 1'b1);
      chk("f0_wrdy", bus.wr_ready, 1'b1);
      chk("f0_rbk", bus.rd_bank, 1'b0);

      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_en   = 1'b1;
         bus.raddr   = AW'(a);
         bus.rd_done = (a == DEPTH-1);
         bus.wr_en   = 1'b1;
         bus.waddr   = AW'(a);
         bus.wdata   = pat(8'h40, a);
         bus.wr_last = (a == DEPTH-1);
         step();
         chk("ov_v", bus.rd_valid, 1'b1);
         chk("ov_d", bus.rdata, pat(8'h00, a));
      end
      idle();
      chk("ov_wbk", bus.wr_bank, 1'b0);
      chk("ov_rbk", bus.rd_bank, 1'b1);
      chk("ov_ravl", bus.rd_avail, 1'b1);
      chk("ov_wrdy", bus.wr_ready, 1'b1);
      step();
      chk("ov_v0", bus.rd_valid, 1'b0);

      fill(8'h80, DEPTH, 1'b1);
      chk("full_wrdy", bus.wr_ready, 1'b0);
      chk("full_wbk", bus.wr_bank, 1'b1);
      chk("full_err0", bus.wr_err, 1'b0);
      bus.wr_en = 1'b1;
      bus.waddr = AW'(5);
      bus.wdata = '1;
      step();
      idle();
      chk("full_err1", bus.wr_err, 1'b1);
      chk("full_wrdy2", bus.wr_ready, 1'b0);

      rd1(0, pat(8'h40, 0), "b1a0");
      rd1(5, pat(8'h40, 5), "b1a5");
      rd1(195, pat(8'h40, 195), "b1a195");
      rd1(200, '0, "oor");
      bus.rd_done = 1'b1;
      step();
      idle();
      chk("rel1_rbk", bus.rd_bank, 1'b0);
      chk("rel1_ravl", bus.rd_avail, 1'b1);
      chk("rel1_wrdy", bus.wr_ready, 1'b1);
      chk("rel1_err", bus.wr_err, 1'b1);
      rd1(5, pat(8'h80, 5), "b0a5");
      bus.rd_done = 1'b1;
      step();
      idle();
      chk("rel0_rbk", bus.rd_bank, 1'b1);
      chk("rel0_ravl", bus.rd_avail, 1'b0);

      bus.rd_en   = 1'b1;
      bus.raddr   = AW'(3);
      bus.rd_done = 1'b1;
      step();
      idle();
      chk("na_v", bus.rd_valid, 1'b0);
      chk("na_hold", bus.rdata, pat(8'h80, 5));
      chk("na_rbk", bus.rd_bank, 1'b1);

      fill(8'hC0, 50, 1'b0);
      chk("mid_wbk", bus.wr_bank, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      reset_chk("mrst");

      fill(8'h20, DEPTH, 1'b1);
      chk("f2_ravl", bus.rd_avail, 1'b1);
      rd1(0, pat(8'h20, 0), "f2a0");
      rd1(49, pat(8'h20, 49), "f2a49");
      rd1(100, pat(8'h20, 100), "f2a100");
      rd1(195, pat(8'h20, 195), "f2a195");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
